// File: rtl/slink_tx_sched_pkg.sv
// Shared types and defaults for the slink TX frame scheduler.
package slink_tx_sched_pkg;

    typedef enum logic [2:0] {
        StInit = 3'd0,
        StIdle = 3'd1,
        StLen  = 3'd2,
        StPay  = 3'd3,
        StChk  = 3'd4,
        StGap  = 3'd5
    } sched_st_e;

    localparam logic [7:0]  SofByteDefault  = 8'hA5;
    localparam int unsigned IfgMinDefault   = 4;
    localparam int unsigned InitIdleDefault = 64;

endpackage

// File: rtl/slink_tx_sched_rr_arb2.sv
// Two-way round-robin picker; the last-granted channel is held by the parent.
module slink_tx_sched_rr_arb2 (
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_ch_i,
    output logic win_ch_o,
    output logic win_vld_o
);

    always_comb begin
        win_vld_o = req0_i | req1_i;
        if (req0_i && req1_i) begin
            win_ch_o = ~last_ch_i;
        end else begin
            win_ch_o = req1_i;
        end
    end

endmodule

// File: rtl/slink_tx_sched.sv
// Frame scheduler ahead of the slink PCS TX encoder: arbitrates two byte streams and
// wraps each grant as SOF, LEN, payload, CHK with guaranteed idle runs between frames.
module slink_tx_sched
    import slink_tx_sched_pkg::*;
#(
    parameter logic [7:0]  SofByte  = SofByteDefault,
    parameter int unsigned IfgMin   = IfgMinDefault,
    parameter int unsigned InitIdle = InitIdleDefault
) (
    input  logic       clk_12_5m,
    input  logic       rst_12_5m,
    input  logic       tx_en_i,
    input  logic       req0_i,
    input  logic       req1_i,
    input  logic [7:0] len0_i,
    input  logic [7:0] len1_i,
    input  logic [7:0] data0_i,
    input  logic [7:0] data1_i,
    output logic       gnt0_o,
    output logic       gnt1_o,
    output logic       rd0_o,
    output logic       rd1_o,
    output logic [7:0] mactx_pcstx_data_o,
    output logic       mactx_pcstx_dval_o,
    output logic       frame_done_o,
    output logic       busy_o
);

    sched_st_e  state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] chk_q, chk_d;
    logic [3:0] gap_q, gap_d;
    logic [7:0] init_q, init_d;
    logic       last_ch_q, last_ch_d;
    logic [1:0] gnt_q, gnt_d;
    logic [7:0] data_q, data_d;
    logic       dval_q, dval_d;
    logic       done_q, done_d;

    logic       win_ch;
    logic       win_vld;
    logic [7:0] win_len;
    logic [7:0] pay_byte;

    slink_tx_sched_rr_arb2 u_arb (
        .req0_i    (req0_i),
        .req1_i    (req1_i),
        .last_ch_i (last_ch_q),
        .win_ch_o  (win_ch),
        .win_vld_o (win_vld)
    );

    assign win_len  = win_ch ? len1_i : len0_i;
    assign pay_byte = gnt_q[1] ? data1_i : data0_i;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        chk_d     = chk_q;
        gap_d     = gap_q;
        init_d    = init_q;
        last_ch_d = last_ch_q;
        gnt_d     = gnt_q;
        data_d    = data_q;
        dval_d    = 1'b0;
        done_d    = 1'b0;
        rd0_o     = 1'b0;
        rd1_o     = 1'b0;

        unique case (state_q)
            StInit: begin
                if (init_q <= 8'd1) begin
                    state_d = StIdle;
                end else begin
                    init_d = init_q - 8'd1;
                end
            end
            StIdle: begin
                // SOF goes out on the grant edge, so the LEN state shows SOF on the line.
                if (tx_en_i && win_vld) begin
                    gnt_d     = win_ch ? 2'b10 : 2'b01;
                    last_ch_d = win_ch;
                    data_d    = SofByte;
                    dval_d    = 1'b1;
                    cnt_d     = win_len;
                    chk_d     = win_len;
                    state_d   = StLen;
                end
            end
            StLen: begin
                data_d  = cnt_q;
                dval_d  = 1'b1;
                state_d = (cnt_q == 8'd0) ? StChk : StPay;
            end
            StPay: begin
                rd0_o  = gnt_q[0];
                rd1_o  = gnt_q[1];
                data_d = pay_byte;
                dval_d = 1'b1;
                chk_d  = chk_q ^ pay_byte;
                cnt_d  = cnt_q - 8'd1;
                if (cnt_q == 8'd1) begin
                    state_d = StChk;
                end
            end
            StChk: begin
                data_d  = chk_q;
                dval_d  = 1'b1;
                done_d  = 1'b1;
                gap_d   = 4'(IfgMin);
                state_d = StGap;
            end
            StGap: begin
                // gnt stays up while the CHK byte is on the line, drops on the first gap edge.
                gnt_d = 2'b00;
                if (gap_q == 4'd0) begin
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            default: begin
                state_d = StInit;
            end
        endcase
    end

    always_ff @(posedge clk_12_5m or negedge rst_12_5m) begin
        if (!rst_12_5m) begin
            state_q   <= StInit;
            cnt_q     <= 8'd0;
            chk_q     <= 8'd0;
            gap_q     <= 4'd0;
            init_q    <= 8'(InitIdle);
            last_ch_q <= 1'b1;
            gnt_q     <= 2'b00;
            data_q    <= 8'h00;
            dval_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            chk_q     <= chk_d;
            gap_q     <= gap_d;
            init_q    <= init_d;
            last_ch_q <= last_ch_d;
            gnt_q     <= gnt_d;
            data_q    <= data_d;
            dval_q    <= dval_d;
            done_q    <= done_d;
        end
    end

    assign gnt0_o             = gnt_q[0];
    assign gnt1_o             = gnt_q[1];
    assign mactx_pcstx_data_o = data_q;
    assign mactx_pcstx_dval_o = dval_q;
    assign frame_done_o       = done_q;
    assign busy_o             = (state_q != StIdle);

endmodule

// File: tb/tb_slink_tx_sched.sv
// Scoreboard bench for slink_tx_sched: expected line bytes are queued when a request is
// raised and compared as the DUT puts them on the line.
module tb_slink_tx_sched;

    localparam int unsigned InitIdle = 64;
    localparam int unsigned IfgMin   = 4;

    logic       clk_12_5m = 1'b0;
    logic       rst_12_5m = 1'b0;
    logic       tx_en, req0, req1;
    logic [7:0] len0, len1, data0, data1;
    logic       gnt0, gnt1, rd0, rd1, dval, frame_done, busy;
    logic [7:0] line_data;

    always #40 clk_12_5m = ~clk_12_5m;

    slink_tx_sched dut (
        .clk_12_5m          (clk_12_5m),
        .rst_12_5m          (rst_12_5m),
        .tx_en_i            (tx_en),
        .req0_i             (req0),
        .req1_i             (req1),
        .len0_i             (len0),
        .len1_i             (len1),
        .data0_i            (data0),
        .data1_i            (data1),
        .gnt0_o             (gnt0),
        .gnt1_o             (gnt1),
        .rd0_o              (rd0),
        .rd1_o              (rd1),
        .mactx_pcstx_data_o (line_data),
        .mactx_pcstx_dval_o (dval),
        .frame_done_o       (frame_done),
        .busy_o             (busy)
    );

    // Show-ahead byte sources, advanced by the DUT pops.
    logic [7:0] mem0 [256];
    logic [7:0] mem1 [256];
    logic [7:0] ptr0, ptr1;
    logic       clr;

    always @(posedge clk_12_5m) begin
        if (clr) begin
            ptr0 <= 8'd0;
            ptr1 <= 8'd0;
        end else begin
            if (rd0) ptr0 <= ptr0 + 8'd1;
            if (rd1) ptr1 <= ptr1 + 8'd1;
        end
    end

    assign data0 = mem0[ptr0];
    assign data1 = mem1[ptr1];

    typedef struct {
        logic [7:0] b;
        logic       done;
        logic [1:0] gnt;
    } exp_t;

    exp_t       sb[$];
    int         gaps[$];
    int         n_cmp, n_err, viol, idle_run, rd0_cnt, rd1_cnt, dval_cnt;
    logic [7:0] last_chk;
    logic [7:0] exp_ptr0, exp_ptr1;
    logic       last_ch_m;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    task automatic push_frame(input int ch, input int len);
        logic [7:0] chk;
        logic [7:0] b;
        logic [1:0] g;
        g   = (ch == 1) ? 2'b10 : 2'b01;
        chk = 8'(len);
        sb.push_back('{b: 8'hA5, done: 1'b0, gnt: g});
        sb.push_back('{b: 8'(len), done: 1'b0, gnt: g});
        for (int i = 0; i < len; i++) begin
            if (ch == 1) begin
                b = mem1[exp_ptr1];
                exp_ptr1 = exp_ptr1 + 8'd1;
            end else begin
                b = mem0[exp_ptr0];
                exp_ptr0 = exp_ptr0 + 8'd1;
            end
            chk = chk ^ b;
            sb.push_back('{b: b, done: 1'b0, gnt: g});
        end
        sb.push_back('{b: chk, done: 1'b1, gnt: g});
        last_ch_m = (ch == 1);
    endtask

    task automatic wait_gnt(input int ch, input int budget);
        int n = 0;
        while (((ch == 1) ? gnt1 : gnt0) !== 1'b1 && n < budget) begin
            @(negedge clk_12_5m);
            n++;
        end
        if (n >= budget) check_eq("gnt_wait", 32'((ch == 1) ? gnt1 : gnt0), 32'd1);
    endtask

    task automatic wait_rd0(input int budget);
        int n = 0;
        while (rd0 !== 1'b1 && n < budget) begin
            @(negedge clk_12_5m);
            n++;
        end
        check_eq("rd0_seen", 32'(rd0), 32'd1);
    endtask

    task automatic wait_empty(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk_12_5m);
            n++;
        end
        check_eq("drain", 32'(sb.size()), 32'd0);
        repeat (IfgMin + 2) @(negedge clk_12_5m);
    endtask

    task automatic check_gap(input string tag, input int idx, input int exp);
        if (idx < gaps.size()) check_eq(tag, 32'(gaps[idx]), 32'(exp));
        else check_eq(tag, 32'hFFFF_FFFF, 32'(exp));
    endtask

    task automatic clr_src();
        clr = 1'b1;
        @(posedge clk_12_5m);
        #1 clr = 1'b0;
        exp_ptr0 = 8'd0;
        exp_ptr1 = 8'd0;
    endtask

    task automatic check_reset_outs(input string tag);
        check_eq({tag, "_gnt"}, 32'({gnt1, gnt0}), 32'd0);
        check_eq({tag, "_rd"}, 32'({rd1, rd0}), 32'd0);
        check_eq({tag, "_data"}, 32'(line_data), 32'd0);
        check_eq({tag, "_dval"}, 32'(dval), 32'd0);
        check_eq({tag, "_done"}, 32'(frame_done), 32'd0);
        check_eq({tag, "_busy"}, 32'(busy), 32'd1);
    endtask

    // Line monitor: pops the scoreboard on every data cycle, tracks idle runs and invariants.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_12_5m);
            if (gnt0 && gnt1) viol++;
            if ((rd0 && !gnt0) || (rd1 && !gnt1)) viol++;
            if ((gnt0 || gnt1 || frame_done) && !dval) viol++;
            if (rd0) rd0_cnt++;
            if (rd1) rd1_cnt++;
            if (!rst_12_5m) begin
                idle_run = 0;
            end else if (dval) begin
                dval_cnt++;
                if (idle_run > 0) gaps.push_back(idle_run);
                idle_run = 0;
                if (frame_done) last_chk = line_data;
                if (sb.size() == 0) begin
                    check_eq("unexpected_byte", 32'(line_data), 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    check_eq("line_byte", 32'(line_data), 32'(e.b));
                    check_eq("frame_done", 32'(frame_done), 32'(e.done));
                    check_eq("gnt", 32'({gnt1, gnt0}), 32'(e.gnt));
                end
            end else begin
                idle_run++;
            end
        end
    end

    initial begin
        int base, rd_base, dv_base, n, ch;
        n_cmp = 0; n_err = 0; viol = 0; idle_run = 0;
        rd0_cnt = 0; rd1_cnt = 0; dval_cnt = 0; last_chk = 8'h00;
        exp_ptr0 = 8'd0; exp_ptr1 = 8'd0; last_ch_m = 1'b1;
        tx_en = 1'b0; req0 = 1'b0; req1 = 1'b0; len0 = 8'd0; len1 = 8'd0; clr = 1'b1;
        for (int i = 0; i < 256; i++) begin
            mem0[i] = 8'(i * 7 + 3);
            mem1[i] = 8'(i * 13 + 5);
        end
        mem0[0] = 8'h11;
        mem0[1] = 8'h22;
        repeat (3) @(posedge clk_12_5m);
        #1 clr = 1'b0;
        check_reset_outs("rst");

        // T1: single len=2 frame after the reset idle run.
        tx_en = 1'b1; req0 = 1'b1; len0 = 8'd2;
        push_frame(0, 2);
        @(negedge clk_12_5m);
        #5 rst_12_5m = 1'b1;
        wait_gnt(0, InitIdle + 10);
        req0 = 1'b0;
        wait_empty(20);
        check_gap("t1_init_idle", 0, InitIdle);
        check_eq("t1_rd0", 32'(rd0_cnt), 32'd2);
        check_eq("t1_chk", 32'(last_chk), 32'h31);

        // T3: zero-length frame on ch1 never pops.
        rd_base = rd1_cnt;
        req1 = 1'b1; len1 = 8'd0;
        push_frame(1, 0);
        wait_gnt(1, 10);
        req1 = 1'b0;
        wait_empty(20);
        check_eq("t3_rd1", 32'(rd1_cnt - rd_base), 32'd0);
        check_eq("t3_chk", 32'(last_chk), 32'h00);

        // T2: both requesting continuously, len=1; grants alternate.
        base = gaps.size();
        req0 = 1'b1; req1 = 1'b1; len0 = 8'd1; len1 = 8'd1;
        for (int k = 0; k < 3; k++) begin
            ch = last_ch_m ? 0 : 1;
            push_frame(ch, 1);
        end
        n = 0;
        while (sb.size() > 3 && n < 60) begin
            @(negedge clk_12_5m);
            n++;
        end
        req0 = 1'b0; req1 = 1'b0;
        wait_empty(20);
        check_gap("t2_gap1", base + 1, IfgMin + 1);
        check_gap("t2_gap2", base + 2, IfgMin + 1);

        // T4: tx_en drops mid-payload; frame completes, no regrant until re-enabled.
        req0 = 1'b1; len0 = 8'd4;
        push_frame(0, 4);
        wait_rd0(20);
        tx_en = 1'b0;
        wait_empty(20);
        dv_base = dval_cnt;
        repeat (20) @(negedge clk_12_5m);
        check_eq("t4_hold", 32'(dval_cnt - dv_base), 32'd0);
        check_eq("t4_busy", 32'(busy), 32'd0);
        push_frame(0, 4);
        tx_en = 1'b1;
        n = 0;
        do begin
            @(posedge clk_12_5m);
            #1 n++;
        end while (dval !== 1'b1 && n < 8);
        check_eq("t4_resume", 32'(n), 32'd1);
        req0 = 1'b0;
        wait_empty(20);

        // T6: maximum length frame with incrementing bytes.
        for (int i = 0; i < 256; i++) mem0[i] = 8'(i);
        clr_src();
        rd_base = rd0_cnt;
        dv_base = dval_cnt;
        req0 = 1'b1; len0 = 8'd255;
        push_frame(0, 255);
        wait_gnt(0, 10);
        req0 = 1'b0;
        wait_empty(300);
        check_eq("t6_rd0", 32'(rd0_cnt - rd_base), 32'd255);
        check_eq("t6_dval", 32'(dval_cnt - dv_base), 32'd258);
        check_eq("t6_chk", 32'(last_chk), 32'h00);

        // T5: reset mid-payload abandons the frame; it restarts after the init idle run.
        req0 = 1'b1; len0 = 8'd8;
        push_frame(0, 8);
        wait_rd0(20);
        #10 rst_12_5m = 1'b0;
        #1 check_reset_outs("t5_rst");
        sb.delete();
        clr_src();
        last_ch_m = 1'b1;
        push_frame(0, 8);
        base = gaps.size();
        @(negedge clk_12_5m);
        #5 rst_12_5m = 1'b1;
        wait_gnt(0, InitIdle + 10);
        req0 = 1'b0;
        wait_empty(30);
        check_gap("t5_init_idle", base, InitIdle);

        check_eq("invariants", 32'(viol), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
